// File: rtl/boot_loader_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_ctrl_if
// Purpose  : Bundles the UART byte stream, the two memory write ports, the
//            acknowledge byte channel and the boot status lines of the boot
//            loader controller. master = controller side, slave = environment.
// Revision : 1.0  initial release
// ============================================================================
interface boot_loader_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  instr_req;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [31:0]           instr_wdata;
  logic                  instr_gnt;
  logic                  data_req;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic                  data_gnt;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  fetch_enable;
  logic                  busy;
  logic                  err;

  modport master (
    input  rx_valid, rx_data, instr_gnt, data_gnt, tx_ready,
    output instr_req, instr_addr, instr_wdata,
    output data_req, data_addr, data_wdata,
    output tx_valid, tx_data, fetch_enable, busy, err
  );

  modport slave (
    output rx_valid, rx_data, instr_gnt, data_gnt, tx_ready,
    input  instr_req, instr_addr, instr_wdata,
    input  data_req, data_addr, data_wdata,
    input  tx_valid, tx_data, fetch_enable, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_ctrl
// Purpose  : Parses little-endian load/boot commands from the UART byte
//            stream, writes 32-bit words into instruction or data memory via
//            request/grant ports, acknowledges every command with one byte
//            and raises fetch_enable once a boot command is acknowledged.
// Revision : 1.0  initial release
// ============================================================================
module boot_loader_ctrl #(
  parameter int         ADDR_WIDTH = 16,
  parameter logic [7:0] ACK_OK     = 8'hA5,
  parameter logic [7:0] ACK_ERR    = 8'hEE
) (
  input  logic                   clk,
  input  logic                   rst,
  boot_loader_ctrl_if.master     bus
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ADDR   = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_CHECK  = 3'd3;
  localparam logic [2:0] c_WRITE  = 3'd4;
  localparam logic [2:0] c_ACK    = 3'd5;
  localparam logic [2:0] c_BOOTED = 3'd6;

  localparam logic [7:0] c_CMD_INSTR = 8'h01;
  localparam logic [7:0] c_CMD_DATA  = 8'h02;
  localparam logic [7:0] c_CMD_BOOT  = 8'h03;

  // First byte address beyond the memory; anything at or above it is rejected.
  localparam logic [63:0] c_ADDR_LIMIT = 64'd1 << (ADDR_WIDTH + 2);

  logic [2:0]  r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_tgt_data;   // 0: instruction memory, 1: data memory
  logic        r_boot;
  logic [7:0]  r_tx_data;
  logic        r_err;

  logic        w_addr_ok;
  logic        w_gnt;
  logic        w_write;
  logic        w_instr_req;
  logic        w_data_req;
  logic        w_tx_valid;
  logic        w_unknown_cmd;
  logic        w_overrun;
  logic        w_set_err;

  assign w_addr_ok   = (r_addr[1:0] == 2'b00) && ({32'd0, r_addr} < c_ADDR_LIMIT);
  assign w_gnt       = r_tgt_data ? bus.data_gnt : bus.instr_gnt;
  assign w_write     = (r_state == c_WRITE);
  assign w_instr_req = w_write && !r_tgt_data;
  assign w_data_req  = w_write &&  r_tgt_data;
  assign w_tx_valid  = (r_state == c_ACK);

  assign w_unknown_cmd = (r_state == c_IDLE) && bus.rx_valid &&
                         (bus.rx_data != c_CMD_INSTR) &&
                         (bus.rx_data != c_CMD_DATA)  &&
                         (bus.rx_data != c_CMD_BOOT);
  // Bytes cannot be buffered while the command is being executed or acked.
  assign w_overrun     = bus.rx_valid &&
                         ((r_state == c_CHECK) || (r_state == c_WRITE) || (r_state == c_ACK));
  assign w_set_err     = w_unknown_cmd || w_overrun || ((r_state == c_CHECK) && !w_addr_ok);

  // Memory ports show the word only while the request is up, zero otherwise.
  assign bus.instr_req    = w_instr_req;
  assign bus.instr_addr   = w_instr_req ? r_addr[ADDR_WIDTH+1:2] : '0;
  assign bus.instr_wdata  = w_instr_req ? r_data : 32'd0;
  assign bus.data_req     = w_data_req;
  assign bus.data_addr    = w_data_req ? r_addr[ADDR_WIDTH+1:2] : '0;
  assign bus.data_wdata   = w_data_req ? r_data : 32'd0;
  assign bus.tx_valid     = w_tx_valid;
  assign bus.tx_data      = w_tx_valid ? r_tx_data : 8'h00;
  assign bus.fetch_enable = (r_state == c_BOOTED);
  assign bus.busy         = (r_state != c_IDLE) && (r_state != c_BOOTED);
  assign bus.err          = r_err;

  // Command FSM together with the little-endian address/data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_cnt      <= 2'd0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_tgt_data <= 1'b0;
      r_boot     <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.rx_valid) begin
            r_cnt <= 2'd0;
            case (bus.rx_data)
              c_CMD_INSTR: begin
                r_tgt_data <= 1'b0;
                r_state    <= c_ADDR;
              end
              c_CMD_DATA: begin
                r_tgt_data <= 1'b1;
                r_state    <= c_ADDR;
              end
              c_CMD_BOOT: begin
                r_boot    <= 1'b1;
                r_tx_data <= ACK_OK;
                r_state   <= c_ACK;
              end
              default: begin
                r_tx_data <= ACK_ERR;
                r_state   <= c_ACK;
              end
            endcase
          end
        end
        c_ADDR: begin
          if (bus.rx_valid) begin
            // Shift in from the top so the first byte ends up as the LSB.
            r_addr <= {bus.rx_data, r_addr[31:8]};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= c_DATA;
            end
          end
        end
        c_DATA: begin
          if (bus.rx_valid) begin
            r_data <= {bus.rx_data, r_data[31:8]};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= c_CHECK;
            end
          end
        end
        c_CHECK: begin
          if (w_addr_ok) begin
            r_state <= c_WRITE;
          end else begin
            r_tx_data <= ACK_ERR;
            r_state   <= c_ACK;
          end
        end
        c_WRITE: begin
          if (w_gnt) begin
            r_tx_data <= ACK_OK;
            r_state   <= c_ACK;
          end
        end
        c_ACK: begin
          if (bus.tx_ready) begin
            r_state <= r_boot ? c_BOOTED : c_IDLE;
          end
        end
        c_BOOTED: begin
          r_state <= c_BOOTED;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
